// File: rtl/alarm_controller_if.sv
// Sensor/actuator bundle between the anti-theft controller and the vehicle.
// The master side supplies the debounced switch inputs; the slave side
// (the controller) returns the armed, siren and status LED indications.
interface alarm_controller_if;
    logic ignition;
    logic door_driver;
    logic door_pass;
    logic armed;
    logic siren;
    logic status_led;

    modport master (
        output ignition,
        output door_driver,
        output door_pass,
        input  armed,
        input  siren,
        input  status_led
    );

    modport slave (
        input  ignition,
        input  door_driver,
        input  door_pass,
        output armed,
        output siren,
        output status_led
    );
endinterface

// File: rtl/alarm_controller.sv
// Arming/alarm state machine of the anti-theft system.
// Contains a one-second tick prescaler and a countdown timer. The timer is
// loaded on entry to a timed state and decremented on each tick; a state
// exits on the edge where tick is high and the timer reads 1.
module alarm_controller #(
    parameter int TICK_DIV    = 100,
    parameter int T_ARM       = 6,
    parameter int T_DRIVER    = 8,
    parameter int T_PASSENGER = 15,
    parameter int T_ALARM     = 10,
    parameter int CNT_W       = 4
) (
    input logic                clock,
    input logic                reset,
    alarm_controller_if.slave  bus_if
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_DISARMED   = 3'd0,
        S_WAIT_OPEN  = 3'd1,
        S_WAIT_CLOSE = 3'd2,
        S_ARMING     = 3'd3,
        S_ARMED      = 3'd4,
        S_TRIGGERED  = 3'd5,
        S_ALARM      = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [CNT_W-1:0]  timer_q;
    logic [CNT_W-1:0]  timer_d;
    logic              led_q;
    logic              led_d;

    logic              tick_s;
    logic              expire_s;
    logic              door_open_s;
    logic              entering_s;
    logic              timed_next_s;
    logic              alarm_hold_s;
    logic              armed_s;
    logic              siren_s;

    assign tick_s       = (presc_q == PW'(TICK_DIV - 1));
    assign expire_s     = tick_s && (timer_q == CNT_W'(1));
    assign door_open_s  = bus_if.door_driver || bus_if.door_pass;
    assign entering_s   = (state_d != state_q);
    assign timed_next_s = (state_d == S_ARMING) || (state_d == S_ARMED) ||
                          (state_d == S_TRIGGERED) || (state_d == S_ALARM);
    // An open door during ALARM keeps the siren countdown pinned at full length.
    assign alarm_hold_s = (state_q == S_ALARM) && (state_d == S_ALARM) && door_open_s;

    // State, prescaler, timer and LED registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_DISARMED;
            presc_q <= {PW{1'b0}};
            timer_q <= {CNT_W{1'b0}};
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            led_q   <= led_d;
        end
    end

    // Next-state logic; ignition overrides every door and timer event.
    always_comb begin
        state_d = state_q;
        if (bus_if.ignition) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_DISARMED: state_d = S_WAIT_OPEN;
                S_WAIT_OPEN: begin
                    if (bus_if.door_driver) state_d = S_WAIT_CLOSE;
                    else                    state_d = state_q;
                end
                S_WAIT_CLOSE: begin
                    if (!bus_if.door_driver) state_d = S_ARMING;
                    else                     state_d = state_q;
                end
                S_ARMING: begin
                    if (door_open_s)   state_d = S_WAIT_CLOSE;
                    else if (expire_s) state_d = S_ARMED;
                    else               state_d = state_q;
                end
                S_ARMED: begin
                    if (door_open_s) state_d = S_TRIGGERED;
                    else             state_d = state_q;
                end
                S_TRIGGERED: begin
                    if (expire_s) state_d = S_ALARM;
                    else          state_d = state_q;
                end
                S_ALARM: begin
                    if (door_open_s)   state_d = state_q;
                    else if (expire_s) state_d = S_ARMED;
                    else               state_d = state_q;
                end
                default: state_d = S_DISARMED;
            endcase
        end
    end

    // Prescaler, timer and LED next values derived from the transition taken.
    always_comb begin
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        timer_d = timer_q;
        led_d   = 1'b0;

        if ((entering_s && timed_next_s) || alarm_hold_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        end

        if (entering_s) begin
            case (state_d)
                S_ARMING:    timer_d = CNT_W'(T_ARM);
                S_TRIGGERED: timer_d = bus_if.door_driver ? CNT_W'(T_DRIVER)
                                                          : CNT_W'(T_PASSENGER);
                S_ALARM:     timer_d = CNT_W'(T_ALARM);
                default:     timer_d = {CNT_W{1'b0}};
            endcase
        end else if (alarm_hold_s) begin
            timer_d = CNT_W'(T_ALARM);
        end else if (tick_s && (timer_q != {CNT_W{1'b0}})) begin
            timer_d = timer_q - CNT_W'(1);
        end else begin
            timer_d = timer_q;
        end

        case (state_d)
            S_ARMED: begin
                if (entering_s)  led_d = 1'b1;
                else if (tick_s) led_d = ~led_q;
                else             led_d = led_q;
            end
            S_TRIGGERED: led_d = 1'b1;
            S_ALARM:     led_d = 1'b1;
            default:     led_d = 1'b0;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        armed_s = 1'b0;
        siren_s = 1'b0;
        case (state_q)
            S_ARMED:     armed_s = 1'b1;
            S_TRIGGERED: armed_s = 1'b1;
            S_ALARM: begin
                armed_s = 1'b1;
                siren_s = 1'b1;
            end
            default: begin
                armed_s = 1'b0;
                siren_s = 1'b0;
            end
        endcase
    end

    assign bus_if.armed      = armed_s;
    assign bus_if.siren      = siren_s;
    assign bus_if.status_led = led_q;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Arming/alarm state machine of the automotive anti-theft system. It is the sensing side that the fuel-pump interlock depends on. It watches ignition and both door switches, arms itself after the driver leaves, and times the entry delays. On an intrusion it drives the siren, and it drives the dashboard status LED at all times. The block contains its own one-second tick prescaler and countdown timer. All inputs arrive already synchronized and debounced.

## Interface
- TICK_DIV, 100: clock cycles per timer tick (one "second"); must be ≥2.
- T_ARM, 6: ticks from driver-door close to armed.
- T_DRIVER, 8: entry delay after the driver door opens while armed.
- T_PASSENGER, 15: entry delay after a passenger door opens while armed.
- T_ALARM, 10: ticks the siren stays on after all doors close.
- CNT_W, 4: timer width; every T_* must satisfy 1 ≤ T_* ≤ 2^CNT_W−1.
- clock  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- ignition  input  1  key switch on.
- door_driver  input  1  driver door open.
- door_pass  input  1  any passenger door open.
- armed  output  1  high in ARMED, TRIGGERED and ALARM.
- siren  output  1  high only in ALARM.
- status_led  output  1  indicator LED.

## Operation
- States: DISARMED, WAIT_OPEN, WAIT_CLOSE, ARMING, ARMED, TRIGGERED, ALARM. Reset enters DISARMED.
- Priority rule: ignition=1 forces DISARMED from every state, and this overrides door and timer events in the same cycle.
- DISARMED: leave for WAIT_OPEN when ignition=0.
- WAIT_OPEN: go to WAIT_CLOSE when door_driver=1.
- WAIT_CLOSE: go to ARMING when door_driver=0.
- ARMING: load T_ARM.
  - door_driver=1 or door_pass=1 returns to WAIT_CLOSE, which restarts arming.
  - Timer expiry goes to ARMED.
- ARMED: stay while both doors are closed.
  - door_driver=1 goes to TRIGGERED with T_DRIVER loaded. This applies even when door_pass=1 in the same cycle.
  - door_pass=1 alone goes to TRIGGERED with T_PASSENGER loaded.
- TRIGGERED: timer expiry goes to ALARM. Closing the door does not cancel the countdown; only ignition does.
- ALARM: siren=1.
  - While either door is open, the timer is held at T_ALARM.
  - With both doors closed, the timer counts down.
  - Expiry returns to ARMED.
  - Reopening a door reloads T_ALARM.
- Outputs armed and siren are decoded from the state register (Moore).
- status_led:
  - 0 in DISARMED, WAIT_OPEN, WAIT_CLOSE and ARMING.
  - 1 in TRIGGERED and ALARM.
  - In ARMED it toggles on every tick, and is set to 1 on the edge that enters ARMED.

## Timing
- Reset values: state DISARMED, prescaler 0, timer 0, armed=0, siren=0, status_led=0.
- Prescaler: free-running counter 0..TICK_DIV−1; tick=1 while prescaler==TICK_DIV−1.
  - It clears to 0 on every edge that enters a timed state (ARMING, ARMED, TRIGGERED, ALARM).
  - In ALARM it also clears on every cycle that a door is open.
- Timer: loaded on state entry and decremented on each tick. The exit transition happens on the edge where tick=1 and timer==1.
- Dwell: ARMING, TRIGGERED and the closed-door part of ALARM each last exactly T×TICK_DIV cycles from the entry (or reload) edge.
- Door and ignition reactions occur on the first rising edge at which the input is sampled. There is no added latency, and outputs follow one edge later than the input change.
- Mid-operation reset clears everything immediately. This applies to a reset during ALARM: siren drops without waiting for a clock edge.

## Test plan
All scenarios use TICK_DIV=4 and the default T_* values.
- Arm sequence: reset; ignition 1→0; door_driver pulse 1 for 3 cycles → ARMING.
  - armed=0 for 24 cycles, then armed=1.
  - status_led=1 at that edge and toggles every 4 cycles.
- Re-arm restart: door_pass=1 at cycle 10 of ARMING → state goes to WAIT_CLOSE, armed stays 0. After the door closes, the full 24-cycle wait is required again.
- Driver entry, no key: armed, door_driver=1 for 1 cycle → status_led=1 steady.
  - siren=1 exactly 32 cycles after the TRIGGERED entry edge.
  - With doors closed, siren clears after 40 more cycles, returning to ARMED.
- Passenger entry then key: door_pass=1 while armed; ignition=1 at TRIGGERED cycle 50 (below 60) → DISARMED next edge, armed=0, siren never asserted.
- Simultaneous doors: door_driver=door_pass=1 in the same cycle while armed → siren after 32 cycles, not 60.
- Alarm hold and reset: in ALARM, hold door_pass=1 for 100 cycles → siren stays 1 throughout.
  - Close the door → siren stays 1 for 40 more cycles.
  - Assert reset mid-alarm → siren=0, armed=0, status_led=0 without waiting for a clock edge.
